ae350_reset_sequencer: RTL and testbench

AE350_RESET_SEQUENCER -- requirements
Module: ae350_reset_sequencer

---
 rtl/ae350_reset_sequencer.sv | 157 +++++++++++++++
 tb/tb_ae350_reset_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ae350_reset_sequencer.sv
// AE350 reset sequencer: PLL lock -> DDR3 init -> POR release -> HW release -> RUN.
// Optional macro RSTSEQ_RETRY_EN makes ERROR retry the whole sequence after HW_HOLD_CYCLES.
module ae350_reset_sequencer #(
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned DDR_TIMEOUT_CYCLES = 1048576,
    parameter int unsigned POR_HOLD_CYCLES    = 256,
    parameter int unsigned HW_HOLD_CYCLES     = 64
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       pll_lock_i,
    input  logic       ddr_init_done_i,
    input  logic       sw_rst_req_i,
    output logic       ddr_rstn_o,
    output logic       por_rstn_o,
    output logic       hw_rstn_o,
    output logic [2:0] state_o,
    output logic       err_o
);

    localparam logic [2:0] ST_LOCK_WAIT = 3'd1;
    localparam logic [2:0] ST_DDR_WAIT  = 3'd2;
    localparam logic [2:0] ST_POR_HOLD  = 3'd3;
    localparam logic [2:0] ST_HW_HOLD   = 3'd4;
    localparam logic [2:0] ST_RUN       = 3'd5;
    localparam logic [2:0] ST_ERROR     = 3'd6;

    // Terminal counts: a state with length N counts 0..N-1.
    localparam logic [23:0] LOCK_LAST = 24'(LOCK_STABLE_CYCLES - 1);
    localparam logic [23:0] DDR_LAST  = 24'(DDR_TIMEOUT_CYCLES - 1);
    localparam logic [23:0] POR_LAST  = 24'(POR_HOLD_CYCLES - 1);
    localparam logic [23:0] HW_LAST   = 24'(HW_HOLD_CYCLES - 1);

    logic [1:0]  lock_sync_q;
    logic [1:0]  done_sync_q;
    logic        lock;
    logic        done;
    logic [2:0]  state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        ddr_rstn_q, por_rstn_q, hw_rstn_q;
    logic        ddr_rstn_d, por_rstn_d, hw_rstn_d;
    logic        lock_lost;
    logic        done_lost;

    assign lock = lock_sync_q[1];
    assign done = done_sync_q[1];

    // State register, counter, sticky error and registered reset outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lock_sync_q <= 2'b00;
            done_sync_q <= 2'b00;
            state_q     <= ST_LOCK_WAIT;
            cnt_q       <= 24'd0;
            err_q       <= 1'b0;
            ddr_rstn_q  <= 1'b0;
            por_rstn_q  <= 1'b0;
            hw_rstn_q   <= 1'b0;
        end else begin
            lock_sync_q <= {lock_sync_q[0], pll_lock_i};
            done_sync_q <= {done_sync_q[0], ddr_init_done_i};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            ddr_rstn_q  <= ddr_rstn_d;
            por_rstn_q  <= por_rstn_d;
            hw_rstn_q   <= hw_rstn_d;
        end
    end

    // Without retry, ERROR is terminal and ignores lock loss.
    always_comb begin
        lock_lost = 1'b0;
        case (state_q)
            ST_DDR_WAIT, ST_POR_HOLD, ST_HW_HOLD, ST_RUN: lock_lost = !lock;
`ifdef RSTSEQ_RETRY_EN
            ST_ERROR:                                     lock_lost = !lock;
`endif
            default:                                      lock_lost = 1'b0;
        endcase
        done_lost = !done && ((state_q == ST_POR_HOLD) || (state_q == ST_HW_HOLD) ||
                              (state_q == ST_RUN));
    end

    // Next-state logic; lock loss outranks init-done loss, which outranks the rest.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 24'd1;
        case (state_q)
            ST_LOCK_WAIT: begin
                if (!lock) begin
                    cnt_d = 24'd0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = ST_DDR_WAIT;
                end
            end
            ST_DDR_WAIT: begin
                if (done) begin
                    state_d = ST_POR_HOLD;
                end else if (cnt_q == DDR_LAST) begin
                    state_d = ST_ERROR;
                end
            end
            ST_POR_HOLD: begin
                if (cnt_q == POR_LAST) state_d = ST_HW_HOLD;
            end
            ST_HW_HOLD: begin
                if (cnt_q == HW_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = 24'd0;
                if (sw_rst_req_i) state_d = ST_HW_HOLD;
            end
            ST_ERROR: begin
`ifdef RSTSEQ_RETRY_EN
                if (cnt_q == HW_LAST) state_d = ST_LOCK_WAIT;
`else
                cnt_d = cnt_q;
`endif
            end
            default: state_d = ST_LOCK_WAIT;
        endcase

        if (lock_lost) begin
            state_d = ST_LOCK_WAIT;
        end else if (done_lost) begin
            state_d = ST_DDR_WAIT;
        end

        if (state_d != state_q) cnt_d = 24'd0;
    end

    // Outputs decode the next state so the registered resets line up with state_q.
    always_comb begin
        err_d      = err_q | ((state_q == ST_DDR_WAIT) && (state_d == ST_ERROR));
        ddr_rstn_d = 1'b1;
        por_rstn_d = 1'b0;
        hw_rstn_d  = 1'b0;
        case (state_d)
            ST_LOCK_WAIT: ddr_rstn_d = 1'b0;
            ST_HW_HOLD:   por_rstn_d = 1'b1;
            ST_RUN: begin
                por_rstn_d = 1'b1;
                hw_rstn_d  = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_o    = state_q;
    assign err_o      = err_q;
    assign ddr_rstn_o = ddr_rstn_q;
    assign por_rstn_o = por_rstn_q;
    assign hw_rstn_o  = hw_rstn_q;

endmodule

// File: tb/tb_ae350_reset_sequencer.sv
// Bench for ae350_reset_sequencer (LOCK_STABLE=8, DDR_TIMEOUT=32, POR_HOLD=4, HW_HOLD=2).
// Output vectors {state, ddr, por, hw, err} are queued as expected and popped on each change.
module tb_ae350_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_lock;
    logic       ddr_done;
    logic       sw_req;
    logic       ddr_rstn;
    logic       por_rstn;
    logic       hw_rstn;
    logic [2:0] state;
    logic       err;

    int         total = 0;
    int         bad = 0;
    logic [6:0] exp_q[$];
    logic [6:0] prev_vec;
    bit         mon_en = 1'b0;

    ae350_reset_sequencer #(
        .LOCK_STABLE_CYCLES(8),
        .DDR_TIMEOUT_CYCLES(32),
        .POR_HOLD_CYCLES(4),
        .HW_HOLD_CYCLES(2)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .pll_lock_i     (pll_lock),
        .ddr_init_done_i(ddr_done),
        .sw_rst_req_i   (sw_req),
        .ddr_rstn_o     (ddr_rstn),
        .por_rstn_o     (por_rstn),
        .hw_rstn_o      (hw_rstn),
        .state_o        (state),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] vec(input logic [2:0] s, input logic d, input logic p,
                                       input logic h, input logic e);
        return {s, d, p, h, e};
    endfunction

    // Scoreboard: every change of the output vector must match the next expected entry.
    always @(negedge clk) begin
        logic [6:0] cur;
        logic [6:0] e;
        if (mon_en) begin
            cur = {state, ddr_rstn, por_rstn, hw_rstn, err};
            if (cur !== prev_vec) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: observed %b, required no change from %b", cur, prev_vec);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        bad++;
                        $display("FAIL sb_sequence: observed %b, required %b", cur, e);
                    end
                end
                prev_vec = cur;
            end
        end
    end

    task automatic wait_state(input logic [2:0] tgt, input int max_cyc, output int n);
        n = 0;
        while (state !== tgt && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; pll_lock = 1'b1; ddr_done = 1'b1; sw_req = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (state !== 3'd1) begin bad++; $display("FAIL reset_state: got %0d required 1", state); end
        total++; if (ddr_rstn !== 1'b0) begin bad++; $display("FAIL reset_ddr: got %b required 0", ddr_rstn); end
        total++; if (por_rstn !== 1'b0) begin bad++; $display("FAIL reset_por: got %b required 0", por_rstn); end
        total++; if (hw_rstn !== 1'b0) begin bad++; $display("FAIL reset_hw: got %b required 0", hw_rstn); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b required 0", err); end
        pll_lock = 1'b0; ddr_done = 1'b0;
        prev_vec = vec(3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        mon_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_nominal();
        int n;
        exp_q.push_back(vec(3'd2, 1'b1, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(vec(3'd3, 1'b1, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(vec(3'd4, 1'b1, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(vec(3'd5, 1'b1, 1'b1, 1'b1, 1'b0));
        pll_lock = 1'b1;
        wait_state(3'd2, 40, n);
        total++; if (n != 10) begin bad++; $display("FAIL nom_lock_to_ddr: got %0d cycles required 10", n); end
        // A software request during DDR_WAIT must be ignored.
        @(negedge clk); sw_req = 1'b1;
        @(negedge clk); sw_req = 1'b0;
        repeat (3) @(negedge clk);
        ddr_done = 1'b1;
        wait_state(3'd3, 20, n);
        total++; if (n != 3) begin bad++; $display("FAIL nom_done_to_por_hold: got %0d cycles required 3", n); end
        wait_state(3'd4, 20, n);
        total++; if (n != 4) begin bad++; $display("FAIL nom_por_hold_len: got %0d cycles required 4", n); end
        wait_state(3'd5, 20, n);
        total++; if (n != 2) begin bad++; $display("FAIL nom_hw_hold_len: got %0d cycles required 2", n); end
        total++; if (hw_rstn !== 1'b1 || por_rstn !== 1'b1 || ddr_rstn !== 1'b1)
            begin bad++; $display("FAIL nom_run_outputs: got %b%b%b required 111", ddr_rstn, por_rstn, hw_rstn); end
    endtask

    task automatic test_sw_reset();
        int low_cnt;
        bit others_ok;
        exp_q.push_back(vec(3'd4, 1'b1, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(vec(3'd5, 1'b1, 1'b1, 1'b1, 1'b0));
        repeat (2) @(negedge clk);
        sw_req = 1'b1;
        @(negedge clk);
        sw_req = 1'b0;
        low_cnt = 0; others_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (hw_rstn === 1'b0) low_cnt++;
            if (por_rstn !== 1'b1 || ddr_rstn !== 1'b1) others_ok = 1'b0;
            @(negedge clk);
        end
        total++; if (low_cnt != 2) begin bad++; $display("FAIL sw_hw_low_len: got %0d cycles required 2", low_cnt); end
        total++; if (!others_ok) begin bad++; $display("FAIL sw_por_ddr_held: got a low sample required always 1"); end
    endtask

    task automatic test_lock_loss_sw();
        exp_q.push_back(vec(3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        pll_lock = 1'b0; ddr_done = 1'b0;
        repeat (2) @(negedge clk);
        sw_req = 1'b1;
        @(negedge clk);
        sw_req = 1'b0;
        total++; if (state !== 3'd1) begin bad++; $display("FAIL lockloss_state: got %0d required 1", state); end
        total++; if ({ddr_rstn, por_rstn, hw_rstn} !== 3'b000)
            begin bad++; $display("FAIL lockloss_resets: got %b%b%b required 000", ddr_rstn, por_rstn, hw_rstn); end
    endtask

    task automatic test_lock_glitch();
        int n;
        repeat (3) @(negedge clk);
        exp_q.push_back(vec(3'd2, 1'b1, 1'b0, 1'b0, 1'b0));
        pll_lock = 1'b1;
        repeat (6) @(negedge clk);
        pll_lock = 1'b0;
        @(negedge clk);
        pll_lock = 1'b1;
        // 2 sync cycles + 8 fresh stable cycles counted from the restored raw lock.
        wait_state(3'd2, 40, n);
        total++; if (n != 10) begin bad++; $display("FAIL glitch_restart: got %0d cycles required 10", n); end
    endtask

    task automatic test_timeout();
        int n;
        bit stuck_ok;
        exp_q.push_back(vec(3'd6, 1'b1, 1'b0, 1'b0, 1'b1));
`ifdef RSTSEQ_RETRY_EN
        exp_q.push_back(vec(3'd1, 1'b0, 1'b0, 1'b0, 1'b1));
`endif
        wait_state(3'd6, 60, n);
        total++; if (n != 32) begin bad++; $display("FAIL timeout_len: got %0d cycles required 32", n); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL timeout_err: got %b required 1", err); end
`ifdef RSTSEQ_RETRY_EN
        wait_state(3'd1, 10, n);
        total++; if (n != 2) begin bad++; $display("FAIL retry_len: got %0d cycles required 2", n); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL retry_err_sticky: got %b required 1", err); end
`else
        stuck_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (state !== 3'd6 || err !== 1'b1) stuck_ok = 1'b0;
        end
        total++; if (!stuck_ok) begin bad++; $display("FAIL error_terminal: got state %0d err %b required 6 1", state, err); end
`endif
    endtask

    task automatic test_async_reset();
        int n;
        exp_q.push_back(vec(3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        total++; if ({state, ddr_rstn, por_rstn, hw_rstn, err} !== 7'b001_0000)
            begin bad++; $display("FAIL async_clear_err: got %0d %b%b%b %b required 1 000 0", state, ddr_rstn, por_rstn, hw_rstn, err); end
        exp_q.push_back(vec(3'd2, 1'b1, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(vec(3'd3, 1'b1, 1'b0, 1'b0, 1'b0));
        ddr_done = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_state(3'd3, 60, n);
        total++; if (n != 11) begin bad++; $display("FAIL async_restart_por: got %0d cycles required 11", n); end
        // A software request in POR_HOLD must be ignored.
        sw_req = 1'b1;
        @(negedge clk);
        sw_req = 1'b0;
        total++; if (state !== 3'd3) begin bad++; $display("FAIL sw_ignored_por: got %0d required 3", state); end
        exp_q.push_back(vec(3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        total++; if ({state, ddr_rstn, por_rstn, hw_rstn, err} !== 7'b001_0000)
            begin bad++; $display("FAIL async_mid_por: got %0d %b%b%b %b required 1 000 0", state, ddr_rstn, por_rstn, hw_rstn, err); end
        exp_q.push_back(vec(3'd2, 1'b1, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(vec(3'd3, 1'b1, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(vec(3'd4, 1'b1, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(vec(3'd5, 1'b1, 1'b1, 1'b1, 1'b0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_state(3'd5, 80, n);
        total++; if (n != 17) begin bad++; $display("FAIL async_recover_run: got %0d cycles required 17", n); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_sw_reset();
        test_lock_loss_sw();
        test_lock_glitch();
        test_timeout();
        test_async_reset();
        repeat (4) @(negedge clk);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d pending required 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
